// File: rtl/x_ramb4_s1_bit_streamer.sv
// Port-A read sequencer for the 4096x1 side of the S1/S8 block RAM: walks an address range
// and presents the bits as a valid/ready serial stream through a small credit-limited FIFO.
// Stream handshake: a bit moves when BIT_VALID && BIT_READY at posedge CLK; BIT_VALID never
// depends on BIT_READY, and once raised it stays high until that bit transfers (or ABORT/RST).
module x_ramb4_s1_bit_streamer #(
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  START,
  input  logic [ADDR_WIDTH-1:0]                 START_ADDR,
  input  logic [12:0]                           LENGTH,
  input  logic                                  ABORT,
  output logic [ADDR_WIDTH-1:0]                 ADDRA,
  output logic                                  ENA,
  output logic                                  WEA,
  input  logic                                  DOA,
  output logic                                  BIT_OUT,
  output logic                                  BIT_VALID,
  input  logic                                  BIT_READY,
  output logic                                  BUSY,
  output logic                                  DONE,
  output logic [12:0]                           BIT_COUNT,
  output logic                                  DBG_STATE,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       DBG_OCCUPANCY
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [12:0]           len_q;
  logic [12:0]           issued_q;
  logic [12:0]           bit_count_q;
  logic [12:0]           len_eff;
  logic                  pending_q;
  logic                  done_q;
  logic                  last_q;
  logic                  mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_cnt;
  logic [CW:0]           occ;
  logic                  run;
  logic                  xfer;
  logic                  rd_en;
  logic                  finish;
  logic                  flush;

  // pending_q marks the read whose DOA is on the bus this cycle; it counts against the credit
  assign run       = (state == RUN);
  assign len_eff   = (LENGTH > 13'd4096) ? 13'd4096 : LENGTH;
  assign occ       = {1'b0, fifo_cnt} + (CW+1)'(pending_q);
  assign BIT_VALID = (fifo_cnt != '0);
  assign xfer      = run && BIT_VALID && BIT_READY && !ABORT;
  assign rd_en     = run && !ABORT && (issued_q != len_q) && (occ < (CW+1)'(FIFO_DEPTH));
  assign finish    = xfer && (bit_count_q + 13'd1 == len_q);
  assign flush     = run && ABORT;

  assign ADDRA         = addr_q;
  assign ENA           = rd_en;
  assign WEA           = 1'b0;
  assign BUSY          = run;
  assign DONE          = done_q;
  assign BIT_COUNT     = bit_count_q;
  assign BIT_OUT       = BIT_VALID ? mem[rd_ptr] : last_q;
  assign DBG_STATE     = state;
  assign DBG_OCCUPANCY = occ[CW-1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      bit_count_q <= '0;
      pending_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      pending_q <= rd_en;
      case (state)
        IDLE: begin
          if (START) begin
            bit_count_q <= '0;
            if (len_eff == 13'd0) begin
              done_q <= 1'b1;
            end else begin
              state    <= RUN;
              addr_q   <= START_ADDR;
              len_q    <= len_eff;
              issued_q <= '0;
            end
          end
        end
        default: begin
          if (ABORT) begin
            state     <= IDLE;
            pending_q <= 1'b0;
          end else begin
            if (rd_en) begin
              addr_q   <= addr_q + 1'b1;
              issued_q <= issued_q + 13'd1;
            end
            if (xfer) bit_count_q <= bit_count_q + 13'd1;
            if (finish) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (pending_q) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (xfer)      rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CW'(pending_q) - CW'(xfer);
    end
  end

  always_ff @(posedge CLK) begin
    if (pending_q) mem[wr_ptr] <= DOA;
  end

  // remembers the bit currently shown so BIT_OUT holds once the FIFO drains
  always_ff @(posedge CLK) begin
    if (RST)            last_q <= 1'b0;
    else if (BIT_VALID) last_q <= mem[rd_ptr];
  end
endmodule

// File: tb/tb_x_ramb4_s1_bit_streamer.sv
// Bench for x_ramb4_s1_bit_streamer: RAM model on port A, expected bit queue built from the
// address/length rules, and a negedge monitor that pops and compares every transferred bit.
module tb_x_ramb4_s1_bit_streamer;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [11:0] START_ADDR = '0;
  logic [12:0] LENGTH = '0;
  logic        ABORT = 1'b0;
  logic [11:0] ADDRA;
  logic        ENA;
  logic        WEA;
  logic        DOA = 1'b0;
  logic        BIT_OUT;
  logic        BIT_VALID;
  logic        BIT_READY = 1'b1;
  logic        BUSY;
  logic        DONE;
  logic [12:0] BIT_COUNT;
  logic        DBG_STATE;
  logic [2:0]  DBG_OCCUPANCY;

  x_ramb4_s1_bit_streamer dut (
    .CLK(CLK), .RST(RST), .START(START), .START_ADDR(START_ADDR), .LENGTH(LENGTH),
    .ABORT(ABORT), .ADDRA(ADDRA), .ENA(ENA), .WEA(WEA), .DOA(DOA), .BIT_OUT(BIT_OUT),
    .BIT_VALID(BIT_VALID), .BIT_READY(BIT_READY), .BUSY(BUSY), .DONE(DONE),
    .BIT_COUNT(BIT_COUNT), .DBG_STATE(DBG_STATE), .DBG_OCCUPANCY(DBG_OCCUPANCY)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  logic       ram [4096];
  logic [0:0] exp_q [$];
  logic [11:0] addr_log [$];
  int errors = 0;
  int checks = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int ena_cnt = 0;
  int occ_max = 0;
  int ready_mode = 0;
  bit log_en = 1'b0;

  always @(posedge CLK) if (ENA) DOA <= ram[ADDRA];

  always @(posedge CLK) begin
    #1;
    case (ready_mode)
      1:       BIT_READY = ~BIT_READY;
      2:       BIT_READY = 1'($urandom_range(0, 1));
      default: BIT_READY = 1'b1;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge CLK) begin
    if (!RST) begin
      if (int'(DBG_OCCUPANCY) > occ_max) occ_max = int'(DBG_OCCUPANCY);
      if (ENA) ena_cnt++;
      if (ENA && log_en) addr_log.push_back(ADDRA);
      if (DONE) done_cnt++;
      if (BIT_VALID && BIT_READY && !ABORT) begin
        xfer_cnt++;
        if (exp_q.size() == 0) chk("unexpected_bit", 32'(BIT_OUT), 32'hdead);
        else chk("stream_bit", 32'(BIT_OUT), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic portb_write(input int byte_addr, input logic [7:0] data);
    for (int b = 0; b < 8; b++) ram[byte_addr*8 + b] = data[b];
  endtask

  // returns in the cycle after START was sampled
  task automatic start_xfer(input logic [11:0] addr, input int len);
    int eff;
    eff = (len > 4096) ? 4096 : len;
    for (int i = 0; i < eff; i++) exp_q.push_back(ram[(int'(addr) + i) % 4096]);
    START_ADDR = addr;
    LENGTH = 13'(len);
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!DONE && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(DONE), 32'd1);
  endtask

  task automatic wait_count(input string name, input int cnt, input int budget);
    int n = 0;
    while (int'(BIT_COUNT) != cnt && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(BIT_COUNT), 32'(cnt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, d0, e0, len, addr;
    logic [7:0] pat;
    for (int i = 0; i < 4096; i++) ram[i] = 1'($urandom_range(0, 1));
    pat = 8'hA5;
    portb_write(2, pat);

    repeat (3) tick();
    chk("rst_addra", 32'(ADDRA), 0);
    chk("rst_ena", 32'(ENA), 0);
    chk("rst_wea", 32'(WEA), 0);
    chk("rst_bit_out", 32'(BIT_OUT), 0);
    chk("rst_valid", 32'(BIT_VALID), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_count", 32'(BIT_COUNT), 0);
    chk("rst_state", 32'(DBG_STATE), 0);
    RST = 1'b0;
    tick();

    // T1: exact latency and bit order of byte 0xA5
    start_xfer(12'h010, 8);
    chk("t1_ena_c1", 32'(ENA), 1);
    chk("t1_addra_c1", 32'(ADDRA), 32'h010);
    chk("t1_busy_c1", 32'(BUSY), 1);
    chk("t1_state_c1", 32'(DBG_STATE), 1);
    tick();
    chk("t1_novalid_c2", 32'(BIT_VALID), 0);
    tick();
    for (int c = 3; c <= 10; c++) begin
      chk("t1_valid_c3_10", 32'(BIT_VALID), 1);
      if (c == 3) chk("t1_first_bit", 32'(BIT_OUT), 1);
      tick();
    end
    chk("t1_done_c11", 32'(DONE), 1);
    chk("t1_busy_c11", 32'(BUSY), 0);
    chk("t1_count", 32'(BIT_COUNT), 8);
    chk("t1_queue_empty", 32'(exp_q.size()), 0);
    tick();
    chk("t1_done_pulse", 32'(DONE), 0);

    // T2: address wrap
    addr_log.delete();
    log_en = 1'b1;
    start_xfer(12'hFFE, 4);
    wait_done("t2_done", 40);
    log_en = 1'b0;
    chk("t2_reads", 32'(addr_log.size()), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      chk("t2_addra_seq", 32'(addr_log[i]), 32'((12'hFFE + i) % 4096));
    chk("t2_count", 32'(BIT_COUNT), 4);
    chk("t2_queue_empty", 32'(exp_q.size()), 0);

    // T3: toggling ready, credit bound
    ready_mode = 1;
    occ_max = 0;
    x0 = xfer_cnt;
    start_xfer(12'h123, 16);
    wait_done("t3_done", 200);
    chk("t3_count", 32'(BIT_COUNT), 16);
    chk("t3_xfers", 32'(xfer_cnt - x0), 16);
    chk("t3_queue_empty", 32'(exp_q.size()), 0);
    chk("t3_occ_le_4", 32'(occ_max <= 4), 1);
    ready_mode = 0;

    // T4: zero length and clamp
    e0 = ena_cnt;
    start_xfer(12'h055, 0);
    chk("t4_zero_done", 32'(DONE), 1);
    chk("t4_zero_busy", 32'(BUSY), 0);
    chk("t4_zero_count", 32'(BIT_COUNT), 0);
    tick();
    chk("t4_zero_done_pulse", 32'(DONE), 0);
    chk("t4_zero_no_ena", 32'(ena_cnt - e0), 0);
    ready_mode = 2;
    x0 = xfer_cnt;
    start_xfer(12'h7A0, 5000);
    wait_done("t4_clamp_done", 20000);
    chk("t4_clamp_count", 32'(BIT_COUNT), 4096);
    chk("t4_clamp_xfers", 32'(xfer_cnt - x0), 4096);
    chk("t4_queue_empty", 32'(exp_q.size()), 0);
    ready_mode = 0;
    tick();

    // T5: abort after five transfers
    start_xfer(12'h200, 20);
    wait_count("t5_reach5", 5, 50);
    d0 = done_cnt;
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    exp_q.delete();
    chk("t5_valid", 32'(BIT_VALID), 0);
    chk("t5_busy", 32'(BUSY), 0);
    chk("t5_done", 32'(DONE), 0);
    repeat (5) tick();
    chk("t5_no_done", 32'(done_cnt - d0), 0);
    start_xfer(12'h3F0, 12);
    wait_done("t5_restart_done", 60);
    chk("t5_restart_count", 32'(BIT_COUNT), 12);
    chk("t5_queue_empty", 32'(exp_q.size()), 0);

    // T6: reset mid-transfer
    start_xfer(12'h400, 30);
    wait_count("t6_reach7", 7, 50);
    d0 = done_cnt;
    RST = 1'b1;
    tick();
    exp_q.delete();
    chk("t6_addra", 32'(ADDRA), 0);
    chk("t6_ena", 32'(ENA), 0);
    chk("t6_bit_out", 32'(BIT_OUT), 0);
    chk("t6_valid", 32'(BIT_VALID), 0);
    chk("t6_busy", 32'(BUSY), 0);
    chk("t6_done", 32'(DONE), 0);
    chk("t6_count", 32'(BIT_COUNT), 0);
    RST = 1'b0;
    repeat (3) tick();
    chk("t6_no_done", 32'(done_cnt - d0), 0);
    start_xfer(12'h00F, 9);
    wait_done("t6_restart_done", 60);
    chk("t6_restart_count", 32'(BIT_COUNT), 9);

    // random transfers under random backpressure
    ready_mode = 2;
    for (int k = 0; k < 6; k++) begin
      addr = $urandom_range(0, 4095);
      len = $urandom_range(1, 40);
      start_xfer(12'(addr), len);
      wait_done("rnd_done", 400);
      chk("rnd_count", 32'(BIT_COUNT), 32'(len));
      chk("rnd_queue_empty", 32'(exp_q.size()), 0);
      tick();
    end
    ready_mode = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
